// File: rtl/fifo_pkg.sv
// Shared sizing helpers and flag-level defaults for the single-clock FIFO family.
package fifo_pkg;

    localparam int AE_LEVEL_DEF  = 4;
    localparam int AF_MARGIN_DEF = 4;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so a completely full FIFO (count == depth) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram_sp.sv
// WIDTH x DEPTH storage with one write and one read port; read is either
// registered (resettable output register) or combinational.
module fifo_ram_sp #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 64,
    parameter int AW      = 6,
    parameter int SYNC_RD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = (SYNC_RD != 0) ? rdata_q : mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO: pointers, occupancy, threshold flags, sticky errors and
// flush; storage lives in fifo_ram_sp.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 64,
    parameter int AF_LEVEL = DEPTH - AF_MARGIN_DEF,
    parameter int AE_LEVEL = AE_LEVEL_DEF,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     clr_err,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          rd_acc, wr_acc, rd_ok, wr_ok;
    logic [WIDTH-1:0] ram_rdata;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (int'(count_q) >= AF_LEVEL);
    assign almost_empty = (int'(count_q) <= AE_LEVEL);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        // Acceptance ignoring flush drives the error flags; flush then masks data movement.
        rd_acc      = rd_en & ~empty;
        wr_acc      = wr_en & (~full | rd_acc);
        rd_ok       = rd_acc & ~flush;
        wr_ok       = wr_acc & ~flush;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_valid_d  = rd_ok;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            rd_valid_d = 1'b0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(1);
            if (wr_ok && !rd_ok) count_d = count_q + CW'(1);
            if (rd_ok && !wr_ok) count_d = count_q - CW'(1);
        end

        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && !wr_acc && !flush) overflow_d  = 1'b1;
        if (rd_en && !rd_acc && !flush) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram_sp #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .AW      (PW),
        .SYNC_RD ((FWFT != 0) ? 0 : 1)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (rd_ok),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // In fall-through mode the head is masked while empty so stale or
    // uninitialised storage never shows on rd_data (e.g. right after reset).
    assign rd_data  = (FWFT != 0) ? (empty ? '0 : ram_rdata) : ram_rdata;
    assign rd_valid = (FWFT != 0) ? ~empty : rd_valid_q;

endmodule
